// File: rtl/axi2ahb_pkg.sv
// rtl/axi2ahb_pkg.sv - shared AHB constants, sequencer state type and width defaults
package axi2ahb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int LEN_W_DEF  = 8;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_INCR = 3'b001;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LAST_DATA,
        ST_ERR,
        ST_DRAIN,
        ST_DONE
    } seq_state_e;

    // Beat sizes above a word are not supported on this bus; fold them onto a word.
    function automatic logic [1:0] clamp_size(input logic [2:0] size);
        return (size > 3'd2) ? 2'd2 : size[1:0];
    endfunction

endpackage

// File: rtl/axi2ahb_addr_gen.sv
// rtl/axi2ahb_addr_gen.sv - burst address, beat counter and NONSEQ/SEQ selection
// Ports:
//   load/load_addr/load_len/load_size : start a new burst (len is beats-1)
//   adv                               : address phase accepted, step address and count
//   drain_pop                         : beat discarded after an error, count only
//   haddr, size                       : current address and latched beat size
//   beats_left                        : beats not yet popped from the FIFO
//   nonseq                            : next beat must be NONSEQ (first beat or 1KB crossing)
//   first_beat                        : no beat of this burst accepted yet
module axi2ahb_addr_gen
    import axi2ahb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [LEN_W-1:0]  load_len,
    input  logic [1:0]        load_size,
    input  logic              adv,
    input  logic              drain_pop,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        size,
    output logic [LEN_W:0]    beats_left,
    output logic              nonseq,
    output logic              first_beat
);

    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic [1:0]        size_q, size_d;
    logic [LEN_W:0]    beats_q, beats_d;
    logic              nonseq_q, nonseq_d;
    logic              first_q, first_d;
    logic [ADDR_W-1:0] next_addr;

    // Natural modulo-2^ADDR_W wrap of the adder is the intended behaviour.
    assign next_addr = haddr_q + (ADDR_W'(1) << size_q);

    always_comb begin
        haddr_d  = haddr_q;
        size_d   = size_q;
        beats_d  = beats_q;
        nonseq_d = nonseq_q;
        first_d  = first_q;
        if (load) begin
            haddr_d  = load_addr;
            size_d   = load_size;
            beats_d  = {1'b0, load_len} + {{LEN_W{1'b0}}, 1'b1};
            nonseq_d = 1'b1;
            first_d  = 1'b1;
        end else if (adv) begin
            haddr_d  = next_addr;
            beats_d  = beats_q - {{LEN_W{1'b0}}, 1'b1};
            // A beat landing on a 1KB boundary must restart the burst.
            nonseq_d = (next_addr[9:0] == 10'd0);
            first_d  = 1'b0;
        end else if (drain_pop) begin
            beats_d  = beats_q - {{LEN_W{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            haddr_q  <= '0;
            size_q   <= '0;
            beats_q  <= '0;
            nonseq_q <= 1'b0;
            first_q  <= 1'b0;
        end else begin
            haddr_q  <= haddr_d;
            size_q   <= size_d;
            beats_q  <= beats_d;
            nonseq_q <= nonseq_d;
            first_q  <= first_d;
        end
    end

    assign haddr      = haddr_q;
    assign size       = size_q;
    assign beats_left = beats_q;
    assign nonseq     = nonseq_q;
    assign first_beat = first_q;

endmodule

// File: rtl/axi2ahb_wr_sequencer.sv
// rtl/axi2ahb_wr_sequencer.sv - turns queued write commands plus FIFO data into AHB INCR write bursts
// Ports:
//   cmd_valid/cmd_ready/cmd_addr/cmd_len/cmd_size : one burst command per handshake
//   fifo_empty/fifo_rd_en/fifo_data               : write-data FIFO read port, one pop per beat
//   haddr/htrans/hwrite/hsize/hburst/hwdata       : AHB master request
//   hready/hresp                                  : AHB slave response
//   done_valid/done_err                           : per-burst completion pulse and error flag
module axi2ahb_wr_sequencer
    import axi2ahb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [2:0]        cmd_size,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_data,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [DATA_W-1:0] hwdata,
    input  logic              hready,
    input  logic              hresp,
    output logic              done_valid,
    output logic              done_err
);

    seq_state_e        state_q, state_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;

    logic              load, adv, drain_pop;
    logic [1:0]        size;
    logic [LEN_W:0]    beats_left;
    logic              nonseq, first_beat;
    logic              err_first;

    axi2ahb_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk        (clk),
        .resetn     (resetn),
        .load       (load),
        .load_addr  (cmd_addr),
        .load_len   (cmd_len),
        .load_size  (clamp_size(cmd_size)),
        .adv        (adv),
        .drain_pop  (drain_pop),
        .haddr      (haddr),
        .size       (size),
        .beats_left (beats_left),
        .nonseq     (nonseq),
        .first_beat (first_beat)
    );

    // First cycle of a two-cycle ERROR response.
    assign err_first = (hresp == HRESP_ERROR) && !hready;

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        hwdata_d   = hwdata_q;
        htrans     = HTRANS_IDLE;
        cmd_ready  = 1'b0;
        fifo_rd_en = 1'b0;
        done_valid = 1'b0;
        done_err   = 1'b0;
        load       = 1'b0;
        adv        = 1'b0;
        drain_pop  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // The async clear already parks the state in IDLE, so gate
                // ready with resetn to keep it low while reset is held.
                cmd_ready = resetn;
                if (cmd_valid && resetn) begin
                    load    = 1'b1;
                    err_d   = 1'b0;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (err_first) begin
                    state_d = ST_ERR;
                end else if (fifo_empty) begin
                    htrans = first_beat ? HTRANS_IDLE : HTRANS_BUSY;
                end else begin
                    htrans = nonseq ? HTRANS_NONSEQ : HTRANS_SEQ;
                    if (hready) begin
                        adv        = 1'b1;
                        fifo_rd_en = 1'b1;
                        hwdata_d   = fifo_data;
                        if (beats_left == {{LEN_W{1'b0}}, 1'b1}) begin
                            state_d = ST_LAST_DATA;
                        end
                    end
                end
            end
            ST_LAST_DATA: begin
                if (err_first) begin
                    state_d = ST_ERR;
                end else if (hready) begin
                    state_d = ST_DONE;
                end
            end
            ST_ERR: begin
                err_d = 1'b1;
                if (hready) begin
                    state_d = (beats_left != '0) ? ST_DRAIN : ST_DONE;
                end
            end
            ST_DRAIN: begin
                // Discard the words of beats that never went out so the FIFO
                // stays aligned with the next command.
                if (beats_left == '0) begin
                    state_d = ST_DONE;
                end else if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    drain_pop  = 1'b1;
                end
            end
            ST_DONE: begin
                done_valid = 1'b1;
                done_err   = err_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            err_q    <= 1'b0;
            hwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            hwdata_q <= hwdata_d;
        end
    end

    assign hwrite = (state_q == ST_ADDR) || (state_q == ST_LAST_DATA) ||
                    (state_q == ST_ERR)  || (state_q == ST_DRAIN);
    assign hsize  = {1'b0, size};
    assign hburst = HBURST_INCR;
    assign hwdata = hwdata_q;

endmodule

// File: tb/tb_axi2ahb_wr_sequencer.sv
// tb/tb_axi2ahb_wr_sequencer.sv - self-checking bench with FIFO/slave models and burst reference model
module tb_axi2ahb_wr_sequencer;
    import axi2ahb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          resetn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic [2:0]    cmd_size;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_data;
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [2:0]    hburst;
    logic [DW-1:0] hwdata;
    logic          hready;
    logic          hresp;
    logic          done_valid;
    logic          done_err;

    always #5 clk = ~clk;

    axi2ahb_wr_sequencer #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_size(cmd_size),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .hburst(hburst), .hwdata(hwdata), .hready(hready), .hresp(hresp),
        .done_valid(done_valid), .done_err(done_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] fifo_q[$];
    logic [31:0] exp_addr[$];
    logic [1:0]  exp_trans[$];
    logic [31:0] exp_word[$];
    int          exp_n, exp_sz;

    int got_beats, got_pops, got_done, accept_cyc, first_cyc;
    logic got_err;
    int err_beat, stall_beat, stall_len, stall_left, err_phase;
    bit rnd_stall;
    int to_push, next_push, push_gap, push_cnt;
    bit dp_active, dp_new, acc_now, pop_now, prev_hold;
    int dp_idx;
    logic [31:0] dp_word, prev_haddr, junk;
    logic [1:0]  prev_htrans;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 0);
        check({tag, "_fifo_rd_en"}, fifo_rd_en, 0);
        check({tag, "_haddr"}, haddr, 0);
        check({tag, "_htrans"}, htrans, HTRANS_IDLE);
        check({tag, "_hwrite"}, hwrite, 0);
        check({tag, "_hsize"}, hsize, 0);
        check({tag, "_hburst"}, hburst, HBURST_INCR);
        check({tag, "_hwdata"}, hwdata, 0);
        check({tag, "_done_valid"}, done_valid, 0);
        check({tag, "_done_err"}, done_err, 0);
    endtask

    // Observe one cycle of settled DUT outputs and score it.
    task automatic sample();
        int idx;
        acc_now = 0;
        dp_new  = 0;
        pop_now = fifo_rd_en && !fifo_empty;
        if (fifo_rd_en) check("rd_en_while_empty", fifo_empty, 0);
        if (cmd_valid && cmd_ready) begin
            acc_now    = 1;
            accept_cyc = cyc;
        end
        if (prev_hold) begin
            check("haddr_hold", haddr, prev_haddr);
            check("htrans_hold", htrans, prev_htrans);
        end
        if (dp_active) check("hwdata", hwdata, dp_word);
        if (err_phase == 1) check("err_cycle1_idle", htrans, HTRANS_IDLE);
        if (hready && htrans[1]) begin
            idx = got_beats;
            if (idx < exp_n) begin
                check("beat_addr", haddr, exp_addr[idx]);
                check("beat_htrans", htrans, exp_trans[idx]);
                check("beat_hsize", hsize, exp_sz);
                check("beat_hwrite", hwrite, 1);
                check("beat_hburst", hburst, HBURST_INCR);
                check("pop_on_accept", pop_now, 1);
                dp_word = exp_word[idx];
            end else begin
                check("beat_count_over", idx + 1, exp_n);
            end
            if (idx == 0) first_cyc = cyc;
            dp_idx = idx;
            dp_new = 1;
            got_beats++;
        end
        if (pop_now) begin
            got_pops++;
            if (!(hready && htrans[1])) check("pop_outside_drain", err_beat != 0, 1);
        end
        if (done_valid) begin
            got_done++;
            got_err = done_err;
        end
        prev_hold   = !hready && htrans[1];
        prev_haddr  = haddr;
        prev_htrans = htrans;
        if (hready) dp_active = dp_new;
    endtask

    // Update FIFO and slave inputs shortly after the clock edge.
    task automatic drive();
        if (acc_now) cmd_valid = 1'b0;
        if (to_push > 0) begin
            if (push_cnt == 0) begin
                fifo_q.push_back(exp_word[next_push]);
                next_push++;
                to_push--;
                push_cnt = push_gap;
            end else begin
                push_cnt--;
            end
        end
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? 32'hDEAD_BEEF : fifo_q[0];
        hresp  = 1'b0;
        hready = 1'b1;
        if (err_phase == 1) begin
            hresp     = 1'b1;
            err_phase = 2;
        end else if (dp_new && dp_idx + 1 == err_beat && err_phase == 0) begin
            hresp     = 1'b1;
            hready    = 1'b0;
            err_phase = 1;
        end else if (stall_left > 0) begin
            hready = 1'b0;
            stall_left--;
        end else if (dp_new && dp_idx + 1 == stall_beat) begin
            hready     = 1'b0;
            stall_left = stall_len - 1;
        end else if (dp_active && rnd_stall && $urandom_range(0, 3) == 0) begin
            hready = 1'b0;
        end
    endtask

    task automatic tick();
        #1;
        sample();
        @(posedge clk);
        if (pop_now && fifo_q.size() > 0) junk = fifo_q.pop_front();
        cyc++;
        #1;
        drive();
    endtask

    task automatic run_burst(input logic [31:0] addr, input int len, input int size,
                             input bit preload, input int gap, input bit rstall,
                             input int errb, input int stallb, input int stalll,
                             input bit use_w0, input logic [31:0] w0, input int abort_at);
        logic [31:0] a;
        int n_bus;
        exp_sz = (size > 2) ? 2 : size;
        exp_n  = len + 1;
        exp_addr.delete(); exp_trans.delete(); exp_word.delete();
        for (int i = 0; i < exp_n; i++) begin
            a = addr + (32'(i) << exp_sz);
            exp_addr.push_back(a);
            exp_trans.push_back((i == 0 || a[9:0] == 10'd0) ? HTRANS_NONSEQ : HTRANS_SEQ);
            exp_word.push_back((i == 0 && use_w0) ? w0 : $urandom);
        end
        n_bus = (errb != 0) ? errb : exp_n;
        got_beats = 0; got_pops = 0; got_done = 0; got_err = 0;
        accept_cyc = -10; first_cyc = -20;
        err_beat = errb; stall_beat = stallb; stall_len = stalll; stall_left = 0;
        err_phase = 0; rnd_stall = rstall;
        dp_active = 0; dp_new = 0; prev_hold = 0;
        if (preload) begin
            foreach (exp_word[i]) fifo_q.push_back(exp_word[i]);
            to_push = 0;
        end else begin
            to_push = exp_n; next_push = 0; push_gap = gap; push_cnt = gap;
        end
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? 32'hDEAD_BEEF : fifo_q[0];
        cmd_addr = addr; cmd_len = LW'(len); cmd_size = 3'(size); cmd_valid = 1'b1;
        for (int c = 0; c < 3000 && got_done == 0; c++) begin
            tick();
            if (abort_at > 0 && got_beats == abort_at) break;
        end
        if (abort_at > 0) begin
            check("abort_reached", got_beats, abort_at);
            resetn = 1'b0;
            #1;
            check_zero_outputs("mid_reset");
            for (int c = 0; c < 3; c++) begin
                @(posedge clk);
                #1;
                check("no_done_in_reset", done_valid, 0);
            end
            fifo_q.delete();
            to_push = 0; cmd_valid = 1'b0; dp_active = 0; dp_new = 0; prev_hold = 0;
            err_phase = 0; stall_left = 0; err_beat = 0; stall_beat = 0;
            fifo_empty = 1'b1; fifo_data = 32'hDEAD_BEEF; hready = 1'b1; hresp = 1'b0;
            resetn = 1'b1;
            #1;
            check("cmd_ready_after_reset", cmd_ready, 1);
            check("no_done_after_abort", got_done, 0);
            return;
        end
        check("done_seen", got_done, 1);
        tick();
        tick();
        check("done_once", got_done, 1);
        check("done_err", got_err, errb != 0);
        check("bus_beats", got_beats, n_bus);
        check("fifo_pops", got_pops, exp_n);
        check("fifo_left", fifo_q.size() + to_push, 0);
        if (preload) check("first_beat_latency", first_cyc, accept_cyc + 1);
    endtask

    initial begin
        resetn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0;
        fifo_empty = 1'b1; fifo_data = 32'hDEAD_BEEF; hready = 1'b1; hresp = 1'b0;
        exp_n = 0; exp_sz = 0; to_push = 0; err_beat = 0; err_phase = 0;
        stall_left = 0; dp_active = 0; dp_new = 0; prev_hold = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_zero_outputs("reset");
        resetn = 1'b1;
        #1;
        check("idle_cmd_ready", cmd_ready, 1);

        // single beat, preloaded word
        run_burst(32'h100, 0, 2, 1, 0, 0, 0, 0, 0, 1, 32'hA5A5_A5A5, 0);
        // FIFO trickles one word every 3 cycles
        run_burst(32'h200, 3, 2, 0, 2, 0, 0, 0, 0, 0, 0, 0);
        // two wait states on beat 2
        run_burst(32'h300, 3, 2, 1, 0, 0, 0, 2, 2, 0, 0, 0);
        // 1KB crossing
        run_burst(32'h3F8, 3, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        // ERROR on beat 2 of 8
        run_burst(32'h500, 7, 2, 1, 0, 0, 2, 0, 0, 0, 0, 0);
        // ERROR on the last beat
        run_burst(32'h600, 3, 1, 0, 1, 0, 4, 0, 0, 0, 0, 0);
        // reset in the middle of beat 3 of 8
        run_burst(32'h700, 7, 2, 1, 0, 0, 0, 0, 0, 0, 0, 3);
        // address wrap and oversize beat
        run_burst(32'hFFFF_FFF8, 3, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        // longest burst
        run_burst(32'h0001_0000, 255, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int r = 0; r < 24; r++) begin
            logic [31:0] ra;
            int rl, rs, rsz, re;
            ra  = $urandom;
            rl  = $urandom_range(0, 15);
            rs  = $urandom_range(0, 3);
            rsz = (rs > 2) ? 2 : rs;
            if ($urandom_range(0, 2) == 0) ra[9:0] = 10'h3F0;
            ra  = ra & ~((32'd1 << rsz) - 32'd1);
            re  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, rl + 1) : 0;
            run_burst(ra, rl, rs, $urandom_range(0, 1) == 1, $urandom_range(0, 3),
                      1, re, 0, 0, 0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
